ifu_fetch_ctrl: RTL and testbench
=================================

# ifu_fetch_ctrl

Fetch controller between the PC register block and the instruction-memory read port. Accepts one fetch address per PC valid/ready handshake, issues it as a single-outstanding AXI-lite-style read (AR/R channels), and presents the returned word to the decode stage. Also kills in-flight fetches on pipeline flush, enforces a response timeout, and flags misaligned-address, bus-error and timeout faults.

## Interface
- `ADDR_W`, 32: fetch address width.
- `DATA_W`, 32: instruction width.
- `TIMEOUT`, 255: maximum cycles to wait in R/DROP for `i_rvalid`; valid range 1..65535.
- `i_clock`  in  1  clock; all state changes on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_pc`  in  ADDR_W  fetch address from the PC block.
- `i_pc_valid`  in  1  `i_pc` is valid.
- `o_pc_ready`  out  1  address accepted this cycle; drives the PC block's advance input.
- `i_flush`  in  1  pipeline redirect; discards all fetch state.
- `o_arvalid`  out  1  read-address valid.
- `o_araddr`  out  ADDR_W  read address.
- `i_arready`  in  1  read-address ready.
- `i_rvalid`  in  1  read-data valid.
- `i_rdata`  in  DATA_W  read data.
- `i_rresp`  in  2  read response; nonzero means error.
- `o_rready`  out  1  read-data ready.
- `o_inst_valid`  out  1  instruction valid to decode.
- `o_inst`  out  DATA_W  instruction word.
- `o_inst_pc`  out  ADDR_W  address of `o_inst`.
- `o_fault`  out  2  fault code: 0 none, 1 misaligned, 2 bus error, 3 timeout.
- `i_inst_ready`  in  1  decode accepts the instruction.

## Operation
- States: IDLE, AR, R, DROP, OUT. Reset state is IDLE.
- **IDLE**
  - `o_pc_ready = i_pc_valid & ~i_flush` (combinational).
  - On accept: latch `i_pc` into the address register.
  - If `i_pc[1:0] != 0`: go to OUT with fault 1 and no bus request. Otherwise go to AR.
- **AR**
  - `o_arvalid = 1`. `o_araddr` is the latched address and holds stable until `i_arready`.
  - `i_arready` without `i_flush`: go to R.
  - `i_arready` with `i_flush`, or after a flush was seen while in AR: go to DROP.
  - `o_arvalid` is never withdrawn before the handshake. A flush seen in AR is recorded in a sticky kill bit.
- **R**
  - `o_rready = 1`. The timeout counter increments each cycle.
  - `i_rvalid` without flush: latch `i_rdata`. Set fault 2 if `i_rresp != 0`, otherwise fault 0. Go to OUT.
  - `i_flush` without `i_rvalid`: go to DROP.
  - `i_flush` with `i_rvalid`: discard the data and go to IDLE.
  - Counter reaches `TIMEOUT`: go to OUT with fault 3 and `o_inst = 0`.
- **DROP**
  - `o_rready = 1`.
  - `i_rvalid` or timeout: go to IDLE with no output.
- **OUT**
  - `o_inst_valid = 1`. `o_inst`, `o_inst_pc` and `o_fault` are stable.
  - `i_inst_ready`: go to IDLE.
  - `i_flush`: go to IDLE. Flush wins over `i_inst_ready`; the instruction counts as not delivered.
- The timeout counter clears on every state entry and has width `$clog2(TIMEOUT+1)`.
- At most one read is outstanding. A second `o_pc_ready` cannot occur before the prior fetch reaches IDLE.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - all outputs to 0;
  - state IDLE;
  - kill bit, counter and data registers to 0.
- Reset mid-transaction abandons the fetch with no drain; the memory port shares the same reset.
- Best-case latency:
  - accept in cycle N;
  - `o_arvalid` in cycle N+1;
  - `i_arready` in N+1, `i_rvalid` in N+2;
  - `o_inst_valid` in cycle N+3.
- Misaligned address: `o_inst_valid` in cycle N+1.
- `o_inst_valid` is registered (a state decode). `o_pc_ready` is the only combinational output.
- `i_flush` in any cycle:
  - `o_inst_valid` is 0 from the next cycle;
  - no instruction from the killed fetch ever appears.

## Structure
- Shared package `ifu_pkg` holds:
  - the state enum (`IFU_IDLE`, `IFU_AR`, `IFU_R`, `IFU_DROP`, `IFU_OUT`);
  - fault codes (`FAULT_NONE`, `FAULT_MISALIGN`, `FAULT_BUS`, `FAULT_TIMEOUT`).
- Sub-module `ifu_fetch_timer`: a counter with clear, enable and parameterised limit that outputs `expired`.
- The remainder of the block is the FSM plus the address, data and fault registers.

## Test plan
- `i_pc=0x30000000` valid, `i_arready` 1 cycle later, `i_rvalid` with `i_rdata=0x00000413` and resp 0 → `o_inst=0x00000413`, `o_inst_pc=0x30000000`, fault 0, valid at N+3; exactly one `o_pc_ready` pulse.
- `i_pc=0x30000002` → no `o_arvalid`; OUT with fault 1 at N+1; held until `i_inst_ready`.
- `i_arready` stalled 5 cycles with a flush in cycle 2 → `o_araddr` stable and `o_arvalid` held until handshake; response drained in DROP; `o_inst_valid` stays 0; next fetch uses the new PC.
- `i_rresp=2'b10` → `o_fault=2`. With `TIMEOUT=4` and no `i_rvalid` → fault 3 exactly 4 cycles after entering R.
- `i_inst_ready` held low 3 cycles in OUT, flush and ready together in the 4th → no delivery; back to IDLE; `o_pc_ready` not asserted while flush is high.
- Assert `i_reset_n=0` while in R → all outputs 0 asynchronously; after release, the first fetch completes normally.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch controller: FSM states and fault codes.
package ifu_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_AR   = 3'd1,
    IFU_R    = 3'd2,
    IFU_DROP = 3'd3,
    IFU_OUT  = 3'd4
  } ifu_state_e;

  typedef logic [1:0] ifu_fault_t;

  localparam ifu_fault_t FAULT_NONE     = 2'd0;
  localparam ifu_fault_t FAULT_MISALIGN = 2'd1;
  localparam ifu_fault_t FAULT_BUS      = 2'd2;
  localparam ifu_fault_t FAULT_TIMEOUT  = 2'd3;

  // Instructions are word aligned; any set low address bit is a fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_timer.sv
// Response timeout counter: clears on request, counts while enabled and flags
// the last permitted cycle so the FSM can leave on the same edge.
module ifu_fetch_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled, saturating at Limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntW'(Limit))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Asserted in the Limit-th enabled cycle, so the wait lasts exactly Limit cycles.
  assign expired_o = enable_i && (cnt_q >= CntW'(Limit - 1));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: takes one PC per handshake, issues a single-outstanding
// AR/R read, and holds the returned word (or a fault) for decode.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_valid,
  output logic              o_pc_ready,
  input  logic              i_flush,
  output logic              o_arvalid,
  output logic [ADDR_W-1:0] o_araddr,
  input  logic              i_arready,
  input  logic              i_rvalid,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  output logic              o_rready,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic [1:0]        o_fault,
  input  logic              i_inst_ready
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  ifu_fault_t        fault_q, fault_d;
  logic              kill_q, kill_d;
  logic              pc_accept;
  logic              tmr_clear, tmr_enable, tmr_expired;

  // Reset is folded in so the only combinational output is also 0 during reset.
  assign pc_accept = i_reset_n && (state_q == IFU_IDLE) && i_pc_valid && !i_flush;

  // Counter restarts on every state change; runs only while waiting for R data.
  assign tmr_clear  = (state_d != state_q);
  assign tmr_enable = (state_q == IFU_R) || (state_q == IFU_DROP);

  ifu_fetch_timer #(
    .Limit(TIMEOUT)
  ) u_timer (
    .clk_i    (i_clock),
    .rst_ni   (i_reset_n),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expired_o(tmr_expired)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IFU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in R a returning beat beats flush, flush beats timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IFU_IDLE: begin
        if (pc_accept) begin
          state_d = is_misaligned(i_pc[1:0]) ? IFU_OUT : IFU_AR;
        end
      end
      IFU_AR: begin
        // AR is never withdrawn; a killed request still completes and is drained.
        if (i_arready) begin
          state_d = (i_flush || kill_q) ? IFU_DROP : IFU_R;
        end
      end
      IFU_R: begin
        if (i_rvalid) begin
          state_d = i_flush ? IFU_IDLE : IFU_OUT;
        end else if (i_flush) begin
          state_d = IFU_DROP;
        end else if (tmr_expired) begin
          state_d = IFU_OUT;
        end
      end
      IFU_DROP: begin
        if (i_rvalid || tmr_expired) begin
          state_d = IFU_IDLE;
        end
      end
      IFU_OUT: begin
        if (i_flush || i_inst_ready) begin
          state_d = IFU_IDLE;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  // Outputs are pure state decodes, apart from the PC handshake.
  always_comb begin
    o_pc_ready   = pc_accept;
    o_arvalid    = (state_q == IFU_AR);
    o_rready     = (state_q == IFU_R) || (state_q == IFU_DROP);
    o_inst_valid = (state_q == IFU_OUT);
  end

  assign o_araddr  = addr_q;
  assign o_inst_pc = addr_q;
  assign o_inst    = data_q;
  assign o_fault   = fault_q;

  // Datapath next-state: address on accept, data/fault on response or timeout.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = fault_q;
    kill_d  = kill_q;
    unique case (state_q)
      IFU_IDLE: begin
        kill_d = 1'b0;
        if (pc_accept) begin
          addr_d  = i_pc;
          data_d  = '0;
          fault_d = is_misaligned(i_pc[1:0]) ? FAULT_MISALIGN : FAULT_NONE;
        end
      end
      IFU_AR: begin
        // Sticky: a flush seen any time before the AR handshake kills the fetch.
        kill_d = kill_q || i_flush;
      end
      IFU_R: begin
        if (i_rvalid) begin
          if (!i_flush) begin
            data_d  = i_rdata;
            fault_d = (|i_rresp) ? FAULT_BUS : FAULT_NONE;
          end
        end else if (!i_flush && tmr_expired) begin
          data_d  = '0;
          fault_d = FAULT_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Address, data, fault and kill registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      fault_q <= FAULT_NONE;
      kill_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomised scoreboard bench for ifu_fetch_ctrl: a driver acts as PC block,
// memory and decode; a monitor checks every delivered instruction.
module tb_ifu_fetch_ctrl;

  localparam int unsigned TMO = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_pc;
  logic        i_pc_valid, o_pc_ready, i_flush;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;
  logic [31:0] o_araddr, i_rdata, o_inst, o_inst_pc;
  logic [1:0]  i_rresp, o_fault;
  logic        o_inst_valid, i_inst_ready;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   pc_ready_cnt = 0;
  int   accepts = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_pc        (i_pc),
    .i_pc_valid  (i_pc_valid),
    .o_pc_ready  (o_pc_ready),
    .i_flush     (i_flush),
    .o_arvalid   (o_arvalid),
    .o_araddr    (o_araddr),
    .i_arready   (i_arready),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .i_rresp     (i_rresp),
    .o_rready    (o_rready),
    .o_inst_valid(o_inst_valid),
    .o_inst      (o_inst),
    .o_inst_pc   (o_inst_pc),
    .o_fault     (o_fault),
    .i_inst_ready(i_inst_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc_ready"}, o_pc_ready, 0);
    check({tag, "_arvalid"}, o_arvalid, 0);
    check({tag, "_araddr"}, o_araddr, 0);
    check({tag, "_rready"}, o_rready, 0);
    check({tag, "_inst_valid"}, o_inst_valid, 0);
    check({tag, "_inst"}, o_inst, 0);
    check({tag, "_inst_pc"}, o_inst_pc, 0);
    check({tag, "_fault"}, o_fault, 0);
  endtask

  // Monitor: every decode handshake must match the oldest expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && o_pc_ready) pc_ready_cnt++;
      if (rst_n && o_inst_valid && i_inst_ready && !i_flush) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_delivery: got pc 0x%0h inst 0x%0h, required none",
                   o_inst_pc, o_inst);
        end else begin
          e = exp_q.pop_front();
          check("inst", o_inst, e.inst);
          check("inst_pc", o_inst_pc, e.pc);
          check("fault", o_fault, e.fault);
        end
      end
    end
  end

  // One complete fetch. fph selects where a flush lands: 0 none, 1 AR, 2 R, 3 OUT;
  // fcyc is the cycle within that phase. r_wait >= TMO means memory never answers.
  task automatic run_fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                           input logic [31:0] data, input logic [1:0] resp, input int fph,
                           input int fcyc, input int out_wait, input bit pre_flush);
    bit   mis;
    bit   has_out;
    bit   done;
    int   k;
    exp_t e;
    mis     = (addr[1:0] != 2'b00);
    has_out = (fph != 1) && (fph != 2);
    if (has_out && fph != 3) begin
      e.pc = addr;
      if (mis) begin
        e.inst = 32'h0; e.fault = 2'd1;
      end else if (r_wait >= int'(TMO)) begin
        e.inst = 32'h0; e.fault = 2'd3;
      end else begin
        e.inst = data; e.fault = (resp != 2'b00) ? 2'd2 : 2'd0;
      end
      exp_q.push_back(e);
    end
    // Request
    @(negedge clk);
    i_pc = addr;
    i_pc_valid = 1'b1;
    if (pre_flush) begin
      i_flush = 1'b1;
      #1;
      check("pc_ready_during_flush", o_pc_ready, 0);
      @(negedge clk);
      i_flush = 1'b0;
    end
    #1;
    k = 0;
    while (!o_pc_ready && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("pc_accept", o_pc_ready, 1);
    accepts++;
    @(negedge clk);
    i_pc_valid = 1'b0;
    i_pc = $urandom;
    if (!mis) begin
      // Address phase
      k = 0;
      forever begin
        i_arready = (k >= ar_wait);
        i_flush   = (fph == 1) && (k == fcyc);
        #1;
        check("arvalid", o_arvalid, 1);
        check("araddr_stable", o_araddr, addr);
        check("no_inst_in_ar", o_inst_valid, 0);
        done = i_arready;
        @(negedge clk);
        if (done) break;
        k++;
      end
      i_arready = 1'b0;
      i_flush = 1'b0;
      // Data phase (R or DROP)
      k = 0;
      forever begin
        i_rvalid = (k >= r_wait);
        i_rdata  = i_rvalid ? data : $urandom;
        i_rresp  = i_rvalid ? resp : 2'($urandom);
        i_flush  = (fph == 2) && (k == fcyc);
        #1;
        check("rready", o_rready, 1);
        check("no_inst_in_r", o_inst_valid, 0);
        done = (i_rvalid && o_rready) || (r_wait >= int'(TMO) && k == int'(TMO) - 1) || k >= 30;
        @(negedge clk);
        if (done) break;
        k++;
      end
      i_rvalid = 1'b0;
      i_flush = 1'b0;
    end
    if (has_out) begin
      k = 0;
      forever begin
        i_inst_ready = (k >= out_wait);
        i_flush      = (fph == 3) && (k == fcyc);
        #1;
        check("inst_valid_held", o_inst_valid, 1);
        check("no_ar_in_out", o_arvalid, 0);
        done = i_inst_ready || i_flush || k >= 30;
        @(negedge clk);
        if (done) break;
        k++;
      end
      i_inst_ready = 1'b0;
      i_flush = 1'b0;
    end
    #1;
    check("idle_no_inst", o_inst_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int arw, rw, ow, fph, fc;
    bit mis, pf;
    logic [31:0] a;
    logic [1:0]  resp;
    rst_n = 1'b0;
    i_pc = 32'h0; i_pc_valid = 1'b1; i_flush = 1'b0;
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
    i_inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    i_pc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_fetch(32'h3000_0000, 0, 0, 32'h0000_0413, 2'b00, 0, 0, 0, 1'b0);
    run_fetch(32'h3000_0002, 0, 0, 32'h0, 2'b00, 0, 0, 3, 1'b0);
    run_fetch(32'h3000_0010, 5, 1, 32'hdead_beef, 2'b00, 1, 2, 0, 1'b0);
    run_fetch(32'h3000_0100, 1, 1, 32'h0010_0093, 2'b00, 0, 0, 0, 1'b0);
    run_fetch(32'h3000_0104, 0, 2, 32'h1234_5678, 2'b10, 0, 0, 1, 1'b0);
    run_fetch(32'h3000_0108, 0, NEVER, 32'h0, 2'b00, 0, 0, 0, 1'b0);
    run_fetch(32'h3000_010c, 0, 0, 32'h0000_0013, 2'b00, 3, 3, 3, 1'b0);
    run_fetch(32'h3000_0110, 0, 2, 32'haaaa_5555, 2'b00, 2, 1, 0, 1'b1);
    run_fetch(32'h3000_0114, 0, 1, 32'h5555_aaaa, 2'b00, 2, 1, 0, 1'b0);

    // Reset while waiting in R
    @(negedge clk);
    i_pc = 32'h4000_0000; i_pc_valid = 1'b1;
    #1;
    check("rst_pc_accept", o_pc_ready, 1);
    accepts++;
    @(negedge clk);
    i_pc_valid = 1'b0; i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0;
    #1;
    check("rst_in_r", o_rready, 1);
    #2;
    rst_n = 1'b0;
    i_pc_valid = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    i_pc_valid = 1'b0;
    rst_n = 1'b1;
    run_fetch(32'h4000_0004, 0, 0, 32'hcafe_f00d, 2'b00, 0, 0, 0, 1'b0);

    // Randomised fetches
    for (int t = 0; t < 60; t++) begin
      a   = $urandom;
      mis = ($urandom_range(0, 7) == 0);
      a[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
      arw = $urandom_range(0, 3);
      rw  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ow  = $urandom_range(0, 3);
      fph = $urandom_range(0, 5);
      if (fph > 3) fph = 0;
      if (mis && (fph == 1 || fph == 2)) fph = 0;
      if (fph == 2 && rw == NEVER) fph = 0;
      fc = (fph == 1) ? $urandom_range(0, arw) :
           (fph == 2) ? $urandom_range(0, rw) :
           (fph == 3) ? $urandom_range(0, ow) : 0;
      pf = ($urandom_range(0, 5) == 0);
      run_fetch(a, arw, rw, $urandom, resp, fph, fc, ow, pf);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("pc_ready_pulses", pc_ready_cnt, accepts);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
